// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_if
//  Purpose  : Instruction-memory request/response bus between the fetch
//             stage (master) and instruction memory (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
//  Module   : fetch
//  Purpose  : RV32I instruction fetch stage. Owns the PC, keeps exactly one
//             instruction-memory request in flight, applies decode-stage
//             redirects and drives the IF/ID pipeline register.
//  Revision : 1.0  initial release
// ============================================================================
module fetch #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0]  NOP_INSTR = 32'h0000_0013
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    fetch_if.master              imem,
    input  wire logic [1:0]      pc_sel,
    input  wire logic            br_true,
    input  wire logic [XLEN-1:0] br_decode,
    input  wire logic [XLEN-1:0] jal_decode,
    input  wire logic [XLEN-1:0] jalr_decode,
    input  wire logic            stall_if,
    input  wire logic            flush_if,
    output logic      [XLEN-1:0] pc_decode,
    output logic      [XLEN-1:0] instr_decode,
    output logic                 valid_decode
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic            drop, drop_nxt;
    logic [XLEN-1:0] hold_buf, hold_buf_nxt;

    logic            redirect;
    logic [XLEN-1:0] target_raw;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_plus4;
    logic            deliver;
    logic [XLEN-1:0] deliver_word;

    // Redirect decode: a stalled decode stage cannot redirect; target is word aligned
    always_comb begin
        redirect = !stall_if &&
                   (pc_sel == 2'd2 || pc_sel == 2'd3 || (pc_sel == 2'd1 && br_true));
        case (pc_sel)
            2'd2:    target_raw = jal_decode;
            2'd3:    target_raw = jalr_decode;
            default: target_raw = br_decode;
        endcase
        target   = target_raw & ~XLEN'(3);
        pc_plus4 = pc + XLEN'(4);
    end

    // Request outputs come straight from state; held low while in reset
    assign imem.imem_req  = rst_n && (state == S_REQ);
    assign imem.imem_addr = pc;

    // Next-state, PC, drop flag and delivery decode
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        drop_nxt     = drop;
        hold_buf_nxt = hold_buf;
        deliver      = 1'b0;
        deliver_word = imem.imem_rdata;
        case (state)
            S_REQ: begin
                if (imem.imem_ready) begin
                    state_nxt = S_WAIT;
                    drop_nxt  = redirect;
                    if (redirect) pc_nxt = target;
                end else if (redirect) begin
                    pc_nxt = target;
                end
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    if (drop || redirect) begin
                        // Stale response: throw it away and refetch
                        if (redirect) pc_nxt = target;
                        drop_nxt  = 1'b0;
                        state_nxt = S_REQ;
                    end else if (!stall_if) begin
                        deliver      = 1'b1;
                        deliver_word = imem.imem_rdata;
                        pc_nxt       = pc_plus4;
                        state_nxt    = S_REQ;
                    end else begin
                        hold_buf_nxt = imem.imem_rdata;
                        state_nxt    = S_HOLD;
                    end
                end else if (redirect) begin
                    // Response still in flight: mark it stale, remember the new target
                    drop_nxt = 1'b1;
                    pc_nxt   = target;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_nxt    = target;
                    state_nxt = S_REQ;
                end else if (!stall_if) begin
                    deliver      = 1'b1;
                    deliver_word = hold_buf;
                    pc_nxt       = pc_plus4;
                    state_nxt    = S_REQ;
                end
            end
            default: begin
                state_nxt = S_REQ;
            end
        endcase
    end

    // FSM and fetch-control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            drop     <= 1'b0;
            hold_buf <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            drop     <= drop_nxt;
            hold_buf <= hold_buf_nxt;
        end
    end

    // IF/ID register: flush beats stall beats delivery, otherwise a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_decode    <= '0;
            instr_decode <= NOP_INSTR;
            valid_decode <= 1'b0;
        end else if (flush_if) begin
            pc_decode    <= '0;
            instr_decode <= NOP_INSTR;
            valid_decode <= 1'b0;
        end else if (stall_if) begin
            pc_decode    <= pc_decode;
            instr_decode <= instr_decode;
            valid_decode <= valid_decode;
        end else if (deliver) begin
            pc_decode    <= pc;
            instr_decode <= deliver_word;
            valid_decode <= 1'b1;
        end else begin
            pc_decode    <= '0;
            instr_decode <= NOP_INSTR;
            valid_decode <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch
//  Purpose  : Directed self-checking bench for the fetch stage. A zero-wait
//             memory returns 32'hA000_0000 | addr for every accepted request.
//             A second instance starts at 32'hFFFF_FFFC to exercise PC wrap.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch;

    localparam int          XLEN = 32;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- DUT A: RESET_PC = 0 ----------------
    fetch_if #(.XLEN(XLEN)) bus_a ();
    logic [1:0]  pc_sel;
    logic        br_true;
    logic [31:0] br_decode, jal_decode, jalr_decode;
    logic        stall_if, flush_if;
    logic [31:0] pc_decode_a, instr_decode_a;
    logic        valid_decode_a;

    logic        a_ready;
    logic        a_rv;
    logic [31:0] a_rd;
    logic        force_en, force_rvalid;
    logic [31:0] force_rdata;

    fetch #(.XLEN(XLEN), .RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem         (bus_a),
        .pc_sel       (pc_sel),
        .br_true      (br_true),
        .br_decode    (br_decode),
        .jal_decode   (jal_decode),
        .jalr_decode  (jalr_decode),
        .stall_if     (stall_if),
        .flush_if     (flush_if),
        .pc_decode    (pc_decode_a),
        .instr_decode (instr_decode_a),
        .valid_decode (valid_decode_a)
    );

    // Zero-wait memory for A: respond the cycle after acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rv <= 1'b0;
            a_rd <= '0;
        end else begin
            a_rv <= bus_a.imem_req && a_ready;
            a_rd <= 32'hA000_0000 | bus_a.imem_addr;
        end
    end
    assign bus_a.imem_ready  = a_ready;
    assign bus_a.imem_rvalid = force_en ? force_rvalid : a_rv;
    assign bus_a.imem_rdata  = force_en ? force_rdata  : a_rd;

    // ---------------- DUT B: RESET_PC = FFFF_FFFC ----------------
    fetch_if #(.XLEN(XLEN)) bus_b ();
    logic [31:0] pc_decode_b, instr_decode_b;
    logic        valid_decode_b;
    logic        b_rv;
    logic [31:0] b_rd;

    fetch #(.XLEN(XLEN), .RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem         (bus_b),
        .pc_sel       (2'd0),
        .br_true      (1'b0),
        .br_decode    (32'h0),
        .jal_decode   (32'h0),
        .jalr_decode  (32'h0),
        .stall_if     (1'b0),
        .flush_if     (1'b0),
        .pc_decode    (pc_decode_b),
        .instr_decode (instr_decode_b),
        .valid_decode (valid_decode_b)
    );

    // Zero-wait memory for B, always ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_rv <= 1'b0;
            b_rd <= '0;
        end else begin
            b_rv <= bus_b.imem_req;
            b_rd <= 32'hA000_0000 | bus_b.imem_addr;
        end
    end
    assign bus_b.imem_ready  = 1'b1;
    assign bus_b.imem_rvalid = b_rv;
    assign bus_b.imem_rdata  = b_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        a_ready      = 1'b1;
        pc_sel       = 2'd0;
        br_true      = 1'b0;
        br_decode    = '0;
        jal_decode   = '0;
        jalr_decode  = '0;
        stall_if     = 1'b0;
        flush_if     = 1'b0;
        force_en     = 1'b0;
        force_rvalid = 1'b0;
        force_rdata  = '0;

        repeat (2) @(negedge clk);
        chk("rst_req_a",   32'(bus_a.imem_req), 32'd0);
        chk("rst_req_b",   32'(bus_b.imem_req), 32'd0);
        chk("rst_pc_dec",  pc_decode_a, 32'h0);
        chk("rst_instr",   instr_decode_a, NOP);
        chk("rst_valid",   32'(valid_decode_a), 32'd0);

        // Release reset away from the clock edge; first request at RESET_PC
        rst_n = 1'b1;
        #1;
        chk("n0_req",      32'(bus_a.imem_req), 32'd1);
        chk("n0_addr",     bus_a.imem_addr, 32'h0);
        chk("n0_addr_b",   bus_b.imem_addr, 32'hFFFF_FFFC);

        @(negedge clk);  // N1: waiting for response
        chk("n1_req",      32'(bus_a.imem_req), 32'd0);
        chk("n1_valid",    32'(valid_decode_a), 32'd0);

        @(negedge clk);  // N2: word 0 delivered, request 4
        chk("n2_addr",     bus_a.imem_addr, 32'h4);
        chk("n2_valid",    32'(valid_decode_a), 32'd1);
        chk("n2_pc_dec",   pc_decode_a, 32'h0);
        chk("n2_instr",    instr_decode_a, 32'hA000_0000);
        chk("wrap_addr_b", bus_b.imem_addr, 32'h0);
        chk("wrap_pc_b",   pc_decode_b, 32'hFFFF_FFFC);
        chk("wrap_ins_b",  instr_decode_b, 32'hFFFF_FFFC);
        chk("wrap_vld_b",  32'(valid_decode_b), 32'd1);

        @(negedge clk);  // N3
        chk("n3_valid",    32'(valid_decode_a), 32'd0);

        @(negedge clk);  // N4: word 4 delivered, request 8
        chk("n4_addr",     bus_a.imem_addr, 32'h8);
        chk("n4_pc_dec",   pc_decode_a, 32'h4);
        chk("n4_instr",    instr_decode_a, 32'hA000_0004);

        @(negedge clk);  // N5: waiting on 0x8; JAL to 0x100
        pc_sel     = 2'd2;
        jal_decode = 32'h100;

        @(negedge clk);  // N6
        chk("jal_addr",    bus_a.imem_addr, 32'h100);
        chk("jal_req",     32'(bus_a.imem_req), 32'd1);
        chk("jal_nodeliv", 32'(valid_decode_a), 32'd0);
        pc_sel = 2'd0;

        @(negedge clk);  // N7: branch not taken
        pc_sel    = 2'd1;
        br_true   = 1'b0;
        br_decode = 32'h40;

        @(negedge clk);  // N8
        chk("bnt_valid",   32'(valid_decode_a), 32'd1);
        chk("bnt_pc_dec",  pc_decode_a, 32'h100);
        chk("bnt_instr",   instr_decode_a, 32'hA000_0100);
        chk("bnt_addr",    bus_a.imem_addr, 32'h104);

        @(negedge clk);  // N9: branch taken while waiting
        br_true = 1'b1;

        @(negedge clk);  // N10
        chk("bt_addr",     bus_a.imem_addr, 32'h40);
        chk("bt_valid",    32'(valid_decode_a), 32'd0);
        pc_sel  = 2'd0;
        br_true = 1'b0;

        @(negedge clk);  // N11: JALR to unaligned target
        pc_sel      = 2'd3;
        jalr_decode = 32'h203;

        @(negedge clk);  // N12
        chk("jalr_addr",   bus_a.imem_addr, 32'h200);
        // Redirect while the request is not accepted
        a_ready    = 1'b0;
        pc_sel     = 2'd2;
        jal_decode = 32'h300;

        @(negedge clk);  // N13
        chk("req_redir_addr", bus_a.imem_addr, 32'h300);
        chk("req_redir_req",  32'(bus_a.imem_req), 32'd1);
        pc_sel  = 2'd0;
        a_ready = 1'b1;

        @(negedge clk);  // N14: response arrives under stall
        stall_if = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);  // N15..N17
            chk("stall_req",   32'(bus_a.imem_req), 32'd0);
            chk("stall_valid", 32'(valid_decode_a), 32'd0);
            chk("stall_instr", instr_decode_a, NOP);
        end
        stall_if = 1'b0;

        @(negedge clk);  // N18: held word delivered
        chk("hold_valid",  32'(valid_decode_a), 32'd1);
        chk("hold_pc_dec", pc_decode_a, 32'h300);
        chk("hold_instr",  instr_decode_a, 32'hA000_0300);
        chk("hold_addr",   bus_a.imem_addr, 32'h304);
        flush_if = 1'b1;
        stall_if = 1'b1;

        @(negedge clk);  // N19: flush wins over stall
        chk("flush_pc",    pc_decode_a, 32'h0);
        chk("flush_instr", instr_decode_a, NOP);
        chk("flush_valid", 32'(valid_decode_a), 32'd0);
        flush_if = 1'b0;
        stall_if = 1'b0;

        @(negedge clk);  // N20
        chk("post_pc_dec", pc_decode_a, 32'h304);
        chk("post_addr",   bus_a.imem_addr, 32'h308);
        stall_if = 1'b1;

        @(negedge clk);  // N21: in S_WAIT with IF/ID held valid
        chk("pre_rst_vld", 32'(valid_decode_a), 32'd1);
        chk("pre_rst_req", 32'(bus_a.imem_req), 32'd0);
        rst_n    = 1'b0;
        stall_if = 1'b0;
        #1;
        chk("arst_valid",  32'(valid_decode_a), 32'd0);
        chk("arst_pc",     pc_decode_a, 32'h0);
        chk("arst_instr",  instr_decode_a, NOP);
        chk("arst_req",    32'(bus_a.imem_req), 32'd0);

        @(negedge clk);  // N22: late response while release
        force_en     = 1'b1;
        force_rvalid = 1'b1;
        force_rdata  = 32'hDEAD_BEEF;
        a_ready      = 1'b0;
        rst_n        = 1'b1;
        #1;
        chk("rel_req",     32'(bus_a.imem_req), 32'd1);
        chk("rel_addr",    bus_a.imem_addr, 32'h0);

        @(negedge clk);  // N23
        chk("late_valid",  32'(valid_decode_a), 32'd0);
        chk("late_addr",   bus_a.imem_addr, 32'h0);

        @(negedge clk);  // N24
        chk("late_instr",  instr_decode_a, NOP);
        force_en = 1'b0;
        a_ready  = 1'b1;

        @(negedge clk);  // N25
        chk("rec_req",     32'(bus_a.imem_req), 32'd0);

        @(negedge clk);  // N26
        chk("rec_valid",   32'(valid_decode_a), 32'd1);
        chk("rec_pc_dec",  pc_decode_a, 32'h0);
        chk("rec_instr",   instr_decode_a, 32'hA000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
